// File: rtl/shader_sequencer_if.sv
// shader_sequencer_if: loader handshake plus the shift/write port of the rotating instruction memory
interface shader_sequencer_if;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_done;
  logic       shift;
  logic       wr_en;
  logic [7:0] wr_data;
  modport master (output load_valid, load_data, input load_ready, load_done, shift, wr_en, wr_data);
  modport slave  (input load_valid, load_data, output load_ready, load_done, shift, wr_en, wr_data);
endinterface

// File: rtl/shader_sequencer.sv
// shader_sequencer: shares the rotating instruction memory shift port between
// per-pixel execution and the program loader; every operation ends with instruction 0 at the head
module shader_sequencer #(
  parameter int NUM_INSTR = 8,
  parameter int CNT_W     = $clog2(NUM_INSTR)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stall_i,
  output logic             exec_valid_o,
  output logic [CNT_W-1:0] instr_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             start_miss_o,
  shader_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, LOAD} state_e;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INSTR - 1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d, wcnt_q, wcnt_d;
  logic             done_q, done_d, load_done_q, load_done_d, miss_q, miss_d;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wcnt_q      <= '0;
      done_q      <= 1'b0;
      load_done_q <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      done_q      <= done_d;
      load_done_q <= load_done_d;
      miss_q      <= miss_d;
    end
  end
  // Combinational outputs are held low while reset is asserted so the memory port stays quiet.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    wcnt_d         = wcnt_q;
    done_d         = 1'b0;
    load_done_d    = 1'b0;
    miss_d         = 1'b0;
    exec_valid_o   = 1'b0;
    instr_idx_o    = '0;
    bus.load_ready = 1'b0;
    bus.shift      = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          bus.load_ready = !start_i;
          if (start_i) begin
            state_d = EXEC;
            idx_d   = '0;
          end else if (bus.load_valid) begin
            bus.shift   = 1'b1;
            bus.wr_en   = 1'b1;
            bus.wr_data = bus.load_data;
            wcnt_d      = CNT_W'(1);
            state_d     = LOAD;
          end
        end
        EXEC: begin
          exec_valid_o = 1'b1;
          instr_idx_o  = idx_q;
          bus.shift    = !stall_i;
          miss_d       = start_i;
          if (!stall_i) begin
            idx_d   = (idx_q == LAST) ? '0 : idx_q + CNT_W'(1);
            state_d = (idx_q == LAST) ? IDLE : EXEC;
            done_d  = (idx_q == LAST);
          end
        end
        LOAD: begin
          bus.load_ready = 1'b1;
          miss_d         = start_i;
          if (bus.load_valid) begin
            bus.shift   = 1'b1;
            bus.wr_en   = 1'b1;
            bus.wr_data = bus.load_data;
            wcnt_d      = (wcnt_q == LAST) ? '0 : wcnt_q + CNT_W'(1);
            state_d     = (wcnt_q == LAST) ? IDLE : LOAD;
            load_done_d = (wcnt_q == LAST);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign start_miss_o  = miss_q;
  assign bus.load_done = load_done_q;
endmodule
